// File: rtl/game_pkg.sv
// Shared constants and types for the score overlay: glyph geometry, BCD score layout.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package game_pkg;

    localparam int GLYPH_W = 20;
    localparam int GLYPH_PIX = 400;
    localparam logic [7:0] TRANSPARENT = 8'h00;
    localparam int SCORE_DIGITS = 3;

    typedef logic [3:0] bcd_digit_t;

    typedef struct packed {
        bcd_digit_t hundreds;
        bcd_digit_t tens;
        bcd_digit_t ones;
    } score_bcd_t;

    // Glyph ROM address: glyphs are stored back to back, row-major, 20 pixels per row.
    // Only constant multiplies; the largest value (9*400 + 19*20 + 19) fits in 12 bits.
    function automatic logic [11:0] glyph_addr(input bcd_digit_t digit,
                                               input logic [4:0] row,
                                               input logic [4:0] col);
        return 12'(digit) * 12'(GLYPH_PIX) + 12'(row) * 12'(GLYPH_W) + 12'(col);
    endfunction

endpackage

// File: rtl/bcd_score_counter.sv
// Three-digit BCD score: clear has priority over increment, increment saturates at 999.
// Latency: score updates on the edge after the clr/inc pulse.
// Backpressure: none; every pulse is accepted.
module bcd_score_counter
    import game_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       inc,
    input  logic       clr,
    output score_bcd_t score
);

    logic at_max;
    assign at_max = (score.hundreds == 4'd9) && (score.tens == 4'd9) && (score.ones == 4'd9);

    // BCD increment with ones->tens->hundreds carry; 999 holds so hundreds never wraps.
    always_ff @(posedge clk) begin
        if (reset) begin
            score <= '0;
        end else if (clr) begin
            score <= '0;
        end else if (inc && !at_max) begin
            if (score.ones != 4'd9) begin
                score.ones <= score.ones + 4'd1;
            end else begin
                score.ones <= 4'd0;
                if (score.tens != 4'd9) begin
                    score.tens <= score.tens + 4'd1;
                end else begin
                    score.tens     <= 4'd0;
                    score.hundreds <= score.hundreds + 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/score_digit_renderer.sv
// Score overlay: keeps the BCD score, latches it per frame, drives glyph ROM addresses and registers pixels.
// Latency: o_numberaddr 1 cycle, o_rgb/o_pixel_on 3 cycles after i_x/i_y/i_video_on.
// Backpressure: none; one pixel per clock in lockstep with the VGA timing.
module score_digit_renderer
    import game_pkg::*;
#(
    parameter logic [9:0] X0            = 10'd560,
    parameter logic [9:0] Y0            = 10'd20,
    parameter logic [9:0] PITCH         = 10'd22,
    parameter int         GLYPH         = 20,
    parameter bit         BLANK_LEADING = 1'b1
) (
    input  logic        i_clk2,
    input  logic        i_reset,
    input  logic [9:0]  i_x,
    input  logic [9:0]  i_y,
    input  logic        i_video_on,
    input  logic        i_frame_start,
    input  logic        i_score_inc,
    input  logic        i_score_clr,
    output logic [11:0] o_numberaddr,
    input  logic [7:0]  i_numberdata,
    output logic [7:0]  o_rgb,
    output logic        o_pixel_on,
    output logic [11:0] o_score_bcd
);

    score_bcd_t score;
    score_bcd_t disp;

    bcd_score_counter u_counter (
        .clk   (i_clk2),
        .reset (i_reset),
        .inc   (i_score_inc),
        .clr   (i_score_clr),
        .score (score)
    );

    assign o_score_bcd = score;

    // Display copy only changes at frame start so a glyph never shows two score values.
    always_ff @(posedge i_clk2) begin
        if (i_reset) begin
            disp <= '0;
        end else if (i_frame_start) begin
            disp <= score;
        end
    end

    // Digit order left to right: hundreds, tens, ones.
    bcd_digit_t                dig [SCORE_DIGITS];
    logic [SCORE_DIGITS-1:0]   blank_k;
    logic [SCORE_DIGITS-1:0]   hit_k;
    logic [11:0]               addr_k [SCORE_DIGITS];

    assign dig[0] = disp.hundreds;
    assign dig[1] = disp.tens;
    assign dig[2] = disp.ones;

    assign blank_k[0] = BLANK_LEADING && (disp.hundreds == 4'd0);
    assign blank_k[1] = BLANK_LEADING && (disp.hundreds == 4'd0) && (disp.tens == 4'd0);
    assign blank_k[2] = 1'b0;

    logic       y_in;
    logic [4:0] row;

    assign y_in = (i_y >= Y0) && (i_y <= Y0 + 10'(GLYPH - 1));
    assign row  = 5'(i_y - Y0);

    for (genvar k = 0; k < SCORE_DIGITS; k++) begin : g_digit
        localparam logic [9:0] GX = X0 + 10'(k) * PITCH;
        logic [4:0] col;
        assign col       = 5'(i_x - GX);
        assign hit_k[k]  = i_video_on && y_in && (i_x >= GX) && (i_x <= GX + 10'(GLYPH - 1));
        assign addr_k[k] = glyph_addr(dig[k], row, col);
    end

    logic [11:0] addr_next;
    logic        hit_next;
    logic        blank_next;

    // Glyph boxes never overlap (PITCH >= width), so the priority order is irrelevant.
    always_comb begin
        addr_next  = '0;
        hit_next   = 1'b0;
        blank_next = 1'b0;
        if (hit_k[0]) begin
            addr_next  = addr_k[0];
            hit_next   = 1'b1;
            blank_next = blank_k[0];
        end else if (hit_k[1]) begin
            addr_next  = addr_k[1];
            hit_next   = 1'b1;
            blank_next = blank_k[1];
        end else if (hit_k[2]) begin
            addr_next  = addr_k[2];
            hit_next   = 1'b1;
            blank_next = blank_k[2];
        end
    end

    logic hit_s1;
    logic blank_s1;
    logic hit_s2;
    logic blank_s2;
    logic pixel_next;

    assign pixel_next = hit_s2 && !blank_s2 && (i_numberdata != TRANSPARENT);

    // S1 registers the ROM address, S2 aligns hit/blank with the ROM read, S3 forms the pixel.
    always_ff @(posedge i_clk2) begin
        if (i_reset) begin
            o_numberaddr <= '0;
            hit_s1       <= 1'b0;
            blank_s1     <= 1'b0;
            hit_s2       <= 1'b0;
            blank_s2     <= 1'b0;
            o_pixel_on   <= 1'b0;
            o_rgb        <= TRANSPARENT;
        end else begin
            o_numberaddr <= addr_next;
            hit_s1       <= hit_next;
            blank_s1     <= blank_next;
            hit_s2       <= hit_s1;
            blank_s2     <= blank_s1;
            o_pixel_on   <= pixel_next;
            o_rgb        <= pixel_next ? i_numberdata : TRANSPARENT;
        end
    end

endmodule

// File: tb/tb_score_digit_renderer.sv
// Scoreboard bench for score_digit_renderer with a registered-read glyph ROM model.
// Latency: expectations are due 1 cycle (address, score) or 3 cycles (pixel) after drive.
// Backpressure: n/a.
module tb_score_digit_renderer;

    localparam logic [9:0] X0 = 10'd560;
    localparam logic [9:0] Y0 = 10'd20;
    localparam logic [9:0] PITCH = 10'd22;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  x = '0;
    logic [9:0]  y = '0;
    logic        vid = 1'b0;
    logic        fs = 1'b0;
    logic        inc = 1'b0;
    logic        clr = 1'b0;
    logic [11:0] addr;
    logic [7:0]  romd;
    logic [7:0]  rgb;
    logic        pon;
    logic [11:0] score;

    always #5 clk = ~clk;

    score_digit_renderer #(
        .X0(X0), .Y0(Y0), .PITCH(PITCH), .GLYPH(20), .BLANK_LEADING(1'b1)
    ) dut (
        .i_clk2        (clk),
        .i_reset       (rst),
        .i_x           (x),
        .i_y           (y),
        .i_video_on    (vid),
        .i_frame_start (fs),
        .i_score_inc   (inc),
        .i_score_clr   (clr),
        .o_numberaddr  (addr),
        .i_numberdata  (romd),
        .o_rgb         (rgb),
        .o_pixel_on    (pon),
        .o_score_bcd   (score)
    );

    // Glyph ROM model: 1-cycle registered read, either a fixed value or an address hash.
    logic       rom_fixed = 1'b0;
    logic [7:0] rom_val = 8'h00;

    function automatic logic [7:0] rom_fn(input logic [11:0] a);
        return 8'(a * 12'd7 + 12'd3);
    endfunction

    always @(posedge clk) romd <= rom_fixed ? rom_val : rom_fn(addr);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, got, exp);
    endtask

    typedef struct { int due; logic [11:0] v; } ev_t;
    typedef struct { int due; logic [7:0] rgb; logic pon; } pix_t;

    ev_t  aq[$];
    ev_t  sq[$];
    pix_t pq[$];

    logic [11:0] m_score = '0;
    logic [11:0] m_disp = '0;

    function automatic int bcd2int(input logic [11:0] b);
        return int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic logic [11:0] int2bcd(input int n);
        logic [11:0] r;
        r[11:8] = 4'(n / 100);
        r[7:4]  = 4'((n / 10) % 10);
        r[3:0]  = 4'(n % 10);
        return r;
    endfunction

    task automatic expect_pixel(input int px, input int py, input logic pv,
                                output logic [11:0] ea, output logic [7:0] ergb, output logic epon);
        int gx;
        int d;
        logic bl;
        logic [7:0] rv;
        ea = '0; ergb = 8'h00; epon = 1'b0;
        if (pv && py >= int'(Y0) && py < int'(Y0) + 20) begin
            for (int k = 0; k < 3; k++) begin
                gx = int'(X0) + k * int'(PITCH);
                if (px >= gx && px < gx + 20) begin
                    d  = (k == 0) ? int'(m_disp[11:8]) : (k == 1) ? int'(m_disp[7:4]) : int'(m_disp[3:0]);
                    ea = 12'(d * 400 + (py - int'(Y0)) * 20 + (px - gx));
                    bl = (k == 0 && m_disp[11:8] == 4'd0) || (k == 1 && m_disp[11:4] == 8'd0);
                    rv = rom_fixed ? rom_val : rom_fn(ea);
                    if (!bl && rv != 8'h00) begin
                        epon = 1'b1;
                        ergb = rv;
                    end
                end
            end
        end
    endtask

    // One clock of stimulus; pushes the address, pixel and score it must produce.
    task automatic step(input int px, input int py, input logic pv,
                        input logic pfs, input logic pinc, input logic pclr);
        ev_t  a;
        ev_t  s;
        pix_t p;
        @(negedge clk);
        rst = 1'b0; x = 10'(px); y = 10'(py); vid = pv; fs = pfs; inc = pinc; clr = pclr;
        expect_pixel(px, py, pv, a.v, p.rgb, p.pon);
        a.due = cyc + 1; p.due = cyc + 3;
        aq.push_back(a); pq.push_back(p);
        if (pfs) m_disp = m_score;
        if (pclr) m_score = '0;
        else if (pinc) m_score = int2bcd((bcd2int(m_score) + 1 > 999) ? 999 : bcd2int(m_score) + 1);
        s.v = m_score; s.due = cyc + 1;
        sq.push_back(s);
    endtask

    // Reset flushes everything in flight; outputs read zero until new inputs propagate.
    task automatic do_reset(input int n);
        ev_t  e;
        pix_t p;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst = 1'b1; vid = 1'b0; fs = 1'b0; inc = 1'b0; clr = 1'b0;
            while (aq.size() > 0 && aq[$].due > cyc) void'(aq.pop_back());
            while (sq.size() > 0 && sq[$].due > cyc) void'(sq.pop_back());
            while (pq.size() > 0 && pq[$].due > cyc) void'(pq.pop_back());
            m_score = '0; m_disp = '0;
            e.v = '0; e.due = cyc + 1;
            aq.push_back(e); sq.push_back(e);
            p.rgb = 8'h00; p.pon = 1'b0;
            for (int d = 1; d <= 3; d++) begin
                p.due = cyc + d;
                pq.push_back(p);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic incs(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic set_rom(input logic f, input logic [7:0] v);
        idle(4);
        rom_fixed = f;
        rom_val = v;
    endtask

    // Compare whatever expectation falls due this cycle.
    always @(negedge clk) begin
        ev_t  e;
        pix_t p;
        if (aq.size() > 0 && aq[0].due == cyc) begin
            e = aq.pop_front();
            check("numberaddr", 32'(addr), 32'(e.v));
        end
        if (sq.size() > 0 && sq[0].due == cyc) begin
            e = sq.pop_front();
            check("score_bcd", 32'(score), 32'(e.v));
        end
        if (pq.size() > 0 && pq[0].due == cyc) begin
            p = pq.pop_front();
            check("pixel_on", 32'(pon), 32'(p.pon));
            check("rgb", 32'(rgb), 32'(p.rgb));
        end
    end

    initial begin
        do_reset(2);
        idle(3);

        // Counting and saturation
        incs(123);
        step(0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        incs(1005);
        step(0, 0, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(2);

        // Frame latch: inc in the frame_start cycle must not reach the display
        set_rom(1'b1, 8'h1C);
        incs(42);
        step(0, 0, 1'b0, 1'b1, 1'b1, 1'b0);
        step(609, 27, 1'b1, 1'b0, 1'b0, 1'b0);
        step(592, 27, 1'b1, 1'b0, 1'b0, 1'b0);
        step(0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(609, 27, 1'b1, 1'b0, 1'b0, 1'b0);

        // Leading-zero blanking and transparency with score 007
        step(0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        incs(7);
        step(0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        set_rom(1'b1, 8'hFF);
        step(565, 30, 1'b1, 1'b0, 1'b0, 1'b0);
        step(590, 30, 1'b1, 1'b0, 1'b0, 1'b0);
        step(610, 30, 1'b1, 1'b0, 1'b0, 1'b0);
        set_rom(1'b1, 8'h00);
        step(610, 30, 1'b1, 1'b0, 1'b0, 1'b0);

        // Gap between glyphs, video off, glyph edges
        set_rom(1'b1, 8'h5A);
        step(580, 30, 1'b1, 1'b0, 1'b0, 1'b0);
        step(610, 30, 1'b0, 1'b0, 1'b0, 1'b0);
        step(604, 20, 1'b1, 1'b0, 1'b0, 1'b0);
        step(623, 39, 1'b1, 1'b0, 1'b0, 1'b0);
        step(624, 39, 1'b1, 1'b0, 1'b0, 1'b0);
        step(610, 40, 1'b1, 1'b0, 1'b0, 1'b0);
        step(603, 19, 1'b1, 1'b0, 1'b0, 1'b0);

        // Random sweep across the score area while the score crosses 100
        set_rom(1'b0, 8'h00);
        step(0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        incs(95);
        step(0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 900; i++) begin
            step($urandom_range(550, 632), $urandom_range(14, 46),
                 ($urandom_range(0, 7) != 0), ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 7) == 0), 1'b0);
        end

        // Reset mid-frame with a hit in flight; display shows 0 afterwards
        set_rom(1'b1, 8'h33);
        step(0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(612, 25, 1'b1, 1'b0, 1'b0, 1'b0);
        do_reset(1);
        step(612, 25, 1'b1, 1'b0, 1'b0, 1'b0);
        step(565, 25, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(4);

        repeat (4) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
